id_issue_ctrl: RTL and testbench

- Parametrised ID-stage issue controller for the PPS MIPS pipeline; successor to the single-cycle stall_reg/stomp logic in the decode stage.
- Keeps an in-flight destination scoreboard across FWD_STAGES downstream stages.
- Generates per-operand forwarding selects, load-use interlock stalls, bubble insertion, multi-slot branch squash and memory-wait freeze.
- Sits between the decoder/register file and the ID/EX pipeline register.

---
 rtl/id_issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_id_issue_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: destination scoreboard, forwarding selects, hazard stalls,
// post-redirect squash and memory-wait freeze. Define ID_FORWARD_EN to enable operand forwarding.
module id_issue_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int FWD_STAGES  = 3,
    parameter int LOAD_LAT    = 1,
    parameter int STOMP_SLOTS = 1,
    parameter int SEL_W       = $clog2(FWD_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_ready,
    input  logic                  data_ready,
    input  logic                  data_busy,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rwe,
    input  logic                  id_load,
    input  logic                  id_redirect,
    output logic [SEL_W-1:0]      fwd_sel_rs,
    output logic [SEL_W-1:0]      fwd_sel_rt,
    output logic                  stall_out,
    output logic                  freeze_out,
    output logic                  issue_out,
    output logic                  stomp_out,
    output logic                  regwrite_out
);

    localparam int               CNT_W      = (STOMP_SLOTS > 1) ? $clog2(STOMP_SLOTS + 1) : 1;
    localparam logic [SEL_W-1:0] LOAD_LAT_K = SEL_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] STOMP_INIT = CNT_W'(STOMP_SLOTS);

    typedef enum logic {IDLE, SQUASH} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // Scoreboard entry k mirrors downstream stage k (1 = EX).
    logic                    sb_vld  [1:FWD_STAGES];
    logic [REG_ADDR_W-1:0]   sb_rd   [1:FWD_STAGES];
    logic                    sb_load [1:FWD_STAGES];

    logic                    freeze, in_squash, issue, stall_hazard, load_stall;
    logic                    hit_rs, hit_rt, win_rs_load, win_rt_load;
    logic [SEL_W-1:0]        win_rs_k, win_rt_k, sel_rs, sel_rt;

    function automatic logic src_hit(input logic                  use_bit,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic                  vld,
                                     input logic [REG_ADDR_W-1:0] rd);
        return use_bit && (src != '0) && vld && (rd == src);
    endfunction

    always_comb begin
        hit_rs      = 1'b0;
        hit_rt      = 1'b0;
        win_rs_k    = '0;
        win_rt_k    = '0;
        win_rs_load = 1'b0;
        win_rt_load = 1'b0;
        // Scan oldest to youngest so the lowest matching stage overrides.
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (src_hit(id_use_rs, id_rs, sb_vld[k], sb_rd[k])) begin
                hit_rs      = 1'b1;
                win_rs_k    = SEL_W'(k);
                win_rs_load = sb_load[k];
            end
            if (src_hit(id_use_rt, id_rt, sb_vld[k], sb_rd[k])) begin
                hit_rt      = 1'b1;
                win_rt_k    = SEL_W'(k);
                win_rt_load = sb_load[k];
            end
        end

        freeze     = ~inst_ready | (data_busy & ~data_ready);
        in_squash  = (state_q == SQUASH);
        load_stall = (hit_rs & win_rs_load & (win_rs_k <= LOAD_LAT_K)) |
                     (hit_rt & win_rt_load & (win_rt_k <= LOAD_LAT_K));
`ifdef ID_FORWARD_EN
        stall_hazard = id_valid & ~in_squash & load_stall;
        sel_rs       = win_rs_k;
        sel_rt       = win_rt_k;
`else
        // Without bypass paths every in-flight producer blocks until it retires.
        stall_hazard = id_valid & ~in_squash & (hit_rs | hit_rt | load_stall);
        sel_rs       = '0;
        sel_rt       = '0;
`endif
        issue = rst_n & id_valid & ~freeze & ~stall_hazard & ~in_squash;

        state_d = state_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            case (state_q)
                IDLE: begin
                    if (issue && id_redirect && (STOMP_SLOTS > 0)) begin
                        state_d = SQUASH;
                        cnt_d   = STOMP_INIT;
                    end
                end
                SQUASH: begin
                    if (cnt_q == CNT_W'(1)) state_d = IDLE;
                    cnt_d = cnt_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign fwd_sel_rs   = rst_n ? sel_rs : '0;
    assign fwd_sel_rt   = rst_n ? sel_rt : '0;
    assign freeze_out   = rst_n & freeze;
    assign stall_out    = rst_n & (freeze | stall_hazard);
    assign stomp_out    = rst_n & in_squash & ~freeze;
    assign issue_out    = issue;
    assign regwrite_out = issue & id_rwe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int k = 1; k <= FWD_STAGES; k++) sb_vld[k] <= 1'b0;
        end else if (!freeze) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sb_vld[1] <= issue & id_rwe & (id_rd != '0);
            for (int k = 2; k <= FWD_STAGES; k++) sb_vld[k] <= sb_vld[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!freeze) begin
            sb_rd[1]   <= id_rd;
            sb_load[1] <= id_load;
            for (int k = 2; k <= FWD_STAGES; k++) begin
                sb_rd[k]   <= sb_rd[k-1];
                sb_load[k] <= sb_load[k-1];
            end
        end
    end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl (STOMP_SLOTS=2); expectations follow the ID_FORWARD_EN build setting.
module tb_id_issue_ctrl;

    localparam int AW = 5;
    localparam int SW = 2;
`ifdef ID_FORWARD_EN
    localparam int RAW_STALLS = 0, RAW_SEL = 1, LU_STALLS = 1, LU_SEL = 2;
`else
    localparam int RAW_STALLS = 3, RAW_SEL = 0, LU_STALLS = 3, LU_SEL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, inst_ready, data_ready, data_busy;
    logic          id_valid, id_use_rs, id_use_rt, id_rwe, id_load, id_redirect;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [SW-1:0] fwd_sel_rs, fwd_sel_rt;
    logic          stall_out, freeze_out, issue_out, stomp_out, regwrite_out;
    int            total = 0;
    int            bad   = 0;

    id_issue_ctrl #(.STOMP_SLOTS(2)) dut (
        .clk(clk), .rst_n(rst_n), .inst_ready(inst_ready), .data_ready(data_ready),
        .data_busy(data_busy), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_rwe(id_rwe),
        .id_load(id_load), .id_redirect(id_redirect), .fwd_sel_rs(fwd_sel_rs),
        .fwd_sel_rt(fwd_sel_rt), .stall_out(stall_out), .freeze_out(freeze_out),
        .issue_out(issue_out), .stomp_out(stomp_out), .regwrite_out(regwrite_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inst(input logic v, input logic [AW-1:0] rs, input logic urs,
                        input logic [AW-1:0] rt, input logic urt, input logic [AW-1:0] rd,
                        input logic rwe, input logic ld, input logic redir);
        id_valid = v;   id_rs = rs;   id_use_rs = urs; id_rt = rt;   id_use_rt = urt;
        id_rd    = rd;  id_rwe = rwe; id_load = ld;    id_redirect = redir;
        #1;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_sel_rs"}, 32'(fwd_sel_rs), 0);
        check({tag, "_sel_rt"}, 32'(fwd_sel_rt), 0);
        check({tag, "_stall"},  32'(stall_out), 0);
        check({tag, "_freeze"}, 32'(freeze_out), 0);
        check({tag, "_issue"},  32'(issue_out), 0);
        check({tag, "_stomp"},  32'(stomp_out), 0);
        check({tag, "_rwe"},    32'(regwrite_out), 0);
    endtask

    task automatic hazard(input string tag, input int nstall, input int exp_sel, input bit on_rt);
        for (int i = 0; i < nstall; i++) begin
            check({tag, "_stall"}, 32'(stall_out), 1);
            check({tag, "_hold"},  32'(issue_out), 0);
            tick();
        end
        check({tag, "_go_stall"}, 32'(stall_out), 0);
        check({tag, "_go_issue"}, 32'(issue_out), 1);
        check({tag, "_sel"}, on_rt ? 32'(fwd_sel_rt) : 32'(fwd_sel_rs), 32'(exp_sel));
    endtask

    task automatic flush();
        inst(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("nop_issue", 32'(issue_out), 0);
        check("nop_stall", 32'(stall_out), 0);
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0; inst_ready = 1'b1; data_ready = 1'b0; data_busy = 1'b0;
        inst(1, 3, 1, 5, 1, 3, 1, 1, 1);
        tick(); tick();
        all_zero("rst");
        inst_ready = 1'b0; #1;
        all_zero("rst_noinst");
        inst_ready = 1'b1;
        tick();
        rst_n = 1'b1;

        // Back-to-back ALU dependency on r3.
        inst(1, 0, 0, 0, 0, 3, 1, 0, 0);
        check("add_issue", 32'(issue_out), 1);
        check("add_rwe",   32'(regwrite_out), 1);
        check("add_stall", 32'(stall_out), 0);
        tick();
        inst(1, 3, 1, 0, 0, 0, 0, 0, 0);
        hazard("raw", RAW_STALLS, RAW_SEL, 1'b0);
`ifdef ID_FORWARD_EN
        tick();
        check("raw2_sel",   32'(fwd_sel_rs), 2);
        check("raw2_issue", 32'(issue_out), 1);
`endif
        tick();
        flush();

        // Load-use on r5 through rt.
        inst(1, 0, 0, 0, 0, 5, 1, 1, 0);
        check("ld_issue", 32'(issue_out), 1);
        tick();
        inst(1, 0, 0, 5, 1, 0, 0, 0, 0);
        hazard("lu", LU_STALLS, LU_SEL, 1'b1);
        tick();
        flush();

        // Jump, two squash slots, freeze held across the second slot.
        inst(1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("jmp_issue", 32'(issue_out), 1);
        check("jmp_stomp", 32'(stomp_out), 0);
        tick();
        inst(1, 7, 1, 0, 0, 7, 1, 0, 1);
        check("sq1_stomp", 32'(stomp_out), 1);
        check("sq1_issue", 32'(issue_out), 0);
        check("sq1_stall", 32'(stall_out), 0);
        check("sq1_rwe",   32'(regwrite_out), 0);
        tick();
        check("sq2_stomp", 32'(stomp_out), 1);
        data_busy = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            check("frz_freeze", 32'(freeze_out), 1);
            check("frz_stall",  32'(stall_out), 1);
            check("frz_stomp",  32'(stomp_out), 0);
            check("frz_issue",  32'(issue_out), 0);
            tick();
        end
        data_busy = 1'b0; #1;
        check("rel_stomp", 32'(stomp_out), 1);
        check("rel_issue", 32'(issue_out), 0);
        tick();
        inst(1, 7, 1, 7, 1, 0, 0, 0, 0);
        check("post_stomp", 32'(stomp_out), 0);
        check("post_issue", 32'(issue_out), 1);
        check("post_stall", 32'(stall_out), 0);
        check("post_sel",   32'(fwd_sel_rs), 0);
        inst_ready = 1'b0; #1;
        check("if_freeze", 32'(freeze_out), 1);
        check("if_stall",  32'(stall_out), 1);
        check("if_issue",  32'(issue_out), 0);
        inst_ready = 1'b1; #1;
        tick();
        flush();

        // r0 is never tracked.
        inst(1, 0, 0, 0, 0, 0, 1, 0, 0);
        check("r0w_issue", 32'(issue_out), 1);
        check("r0w_rwe",   32'(regwrite_out), 1);
        tick();
        inst(1, 0, 1, 0, 1, 0, 0, 0, 0);
        check("r0r_sel_rs", 32'(fwd_sel_rs), 0);
        check("r0r_sel_rt", 32'(fwd_sel_rt), 0);
        check("r0r_stall",  32'(stall_out), 0);
        check("r0r_issue",  32'(issue_out), 1);
        tick();

        // Reset during a load-use stall.
        inst(1, 0, 0, 0, 0, 9, 1, 1, 0);
        check("ld9_issue", 32'(issue_out), 1);
        tick();
        inst(1, 0, 0, 9, 1, 0, 0, 0, 0);
        check("ld9_stall", 32'(stall_out), 1);
        rst_n = 1'b0; #1;
        all_zero("midrst");
        tick();
        rst_n = 1'b1; #1;
        check("arst_stall", 32'(stall_out), 0);
        check("arst_issue", 32'(issue_out), 1);
        check("arst_sel",   32'(fwd_sel_rt), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
